mc_stage_ctrl: RTL and testbench
================================

# mc_stage_ctrl

Multi-cycle stage controller for the 32-bit CPU datapath. It consumes the instruction word held in the negedge-loaded instruction register and steps each instruction through fetch, decode, execute, memory and write-back. It emits the per-stage write enables for the PC, instruction register, register file and data memory. It sits directly downstream of the instruction register and upstream of every datapath register enable.

## Interface
- `OP_RTYPE`, default 6'b000000: opcode of R-type instructions.
- `OP_LW`, default 6'b100011: load word.
- `OP_SW`, default 6'b101011: store word.
- `OP_BEQ`, default 6'b000100: branch on equal.
- `OP_J`, default 6'b000010: jump.
- `OP_HALT`, default 6'b111111: halt.
- `CLK`  input  1: system clock; the state register updates on the posedge.
- `Reset`  input  1: asynchronous, active-low reset.
- `instr`  input  32: instruction register output; only `instr[31:26]` is used.
- `mem_ready`  input  1: data memory completion, sampled in MEM.
- `IRWre`  output  1: instruction register load enable.
- `PCWre`  output  1: PC update enable.
- `RegWre`  output  1: register file write enable.
- `MemRead`  output  1: data memory read strobe.
- `MemWrite`  output  1: data memory write strobe.
- `state`  output  3: current state code.
- `halted`  output  1: high while in the HALT state.
- `cycle_cnt`  output  32: cycles since reset (see Configuration).
- `retire_cnt`  output  32: instructions retired (see Configuration).

## Operation
- State codes: IF=3'd0, ID=3'd1, EXE=3'd2, MEM=3'd3, WB=3'd4, HALT=3'd5. Codes 6 and 7 are illegal and go to IF on the next edge.
- Outputs are Moore-style, decoded from `state` plus the opcode `op = instr[31:26]`. The opcode is stable from ID onward because the instruction register loads on the negedge during IF.
- IF: `IRWre`=1. Next state is ID.
- ID:
  - `op`=J: `PCWre`=1, next state IF.
  - `op`=HALT: next state HALT.
  - `op` is R, LW, SW or BEQ: next state EXE.
  - Any other opcode is a NOP: `PCWre`=1, next state IF.
- EXE:
  - BEQ: `PCWre`=1, next state IF.
  - R: next state WB.
  - LW or SW: next state MEM.
- MEM:
  - LW asserts `MemRead`=1; SW asserts `MemWrite`=1.
  - While `mem_ready`=0 the block stays in MEM with the strobe held.
  - When `mem_ready`=1: SW gives `PCWre`=1 and goes to IF; LW goes to WB.
- WB: `RegWre`=1, `PCWre`=1. Next state IF.
- HALT: all enables are 0 and `halted`=1. Only `Reset` leaves this state.
- A retire is any edge taken with `PCWre`=1. The CPI is therefore: J/NOP 2, BEQ 3, R 4, SW 4+wait, LW 5+wait.

## Timing
- While `Reset`=0 (asynchronous):
  - `state`=IF.
  - Counters are 0.
  - Outputs: `IRWre`=1, all other enables 0, `halted`=0.
- Reset deasserted mid-instruction: the next posedge starts a fresh IF → ID sequence. No partial enables are emitted afterward.
- Every enable is valid for the whole cycle in which it is asserted. The datapath commits on the following edge.
- At most one of `RegWre`, `MemRead`, `MemWrite` is high in any cycle. `PCWre` is high in exactly one cycle per retired instruction.
- `mem_ready` is ignored outside MEM.
- `mem_ready` held high through MEM gives zero wait states.

## Configuration
- Macro: `MC_STAGE_CTRL_PERF_EN`.
- Defined:
  - `cycle_cnt` increments on every posedge while not in HALT.
  - `retire_cnt` increments on every edge with `PCWre`=1.
  - Both are 32-bit and wrap from 32'hFFFF_FFFF to 0.
- Undefined: both counters are absent and the two outputs are tied to 32'd0.

## Test plan
- Reset while in state MEM, release, apply `op`=R (32'h0000_0020) → states 0,1,2,4,0. `RegWre` and `PCWre` high only in WB. `retire_cnt`=1.
- LW (32'h8C01_0004) with `mem_ready` low for 2 MEM cycles → `MemRead` high for 3 cycles, then WB. 7 cycles total. `retire_cnt` +1.
- SW (32'hAC01_0004) with `mem_ready`=1 → `MemWrite` and `PCWre` high together in a single MEM cycle. `RegWre` is never high.
- BEQ then J then undefined opcode 6'b111000 → retire in 3, 2 and 2 cycles respectively. `cycle_cnt`=7.
- HALT (32'hFC00_0000) → `state`=5 and `halted`=1 from the third cycle. All enables stay 0 for 10 or more cycles. `cycle_cnt` frozen. Reset returns to IF.
- Force `cycle_cnt` near wrap (preload 32'hFFFF_FFFE via testbench force/release), run 3 cycles → reads 32'd1. With the macro undefined, both counters read 0.

Source files
------------

// File: rtl/mc_stage_ctrl_if.sv
// Bus between the multi-cycle stage controller and the datapath it drives:
// instruction/memory status in, per-stage write enables and status out.
interface mc_stage_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        IRWre;
    logic        PCWre;
    logic        RegWre;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;

    // The controller side issues enables; the datapath side consumes them.
    modport master (
        input  instr, mem_ready,
        output IRWre, PCWre, RegWre, MemRead, MemWrite,
        output state, halted, cycle_cnt, retire_cnt
    );

    modport slave (
        output instr, mem_ready,
        input  IRWre, PCWre, RegWre, MemRead, MemWrite,
        input  state, halted, cycle_cnt, retire_cnt
    );
endinterface

// File: rtl/mc_stage_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB stage controller for the 32-bit CPU datapath.
// Optional cycle/retire counters are enabled by defining MC_STAGE_CTRL_PERF_EN.
module mc_stage_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_HALT  = 6'b111111
) (
    input  logic           CLK,
    input  logic           Reset,
    mc_stage_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t     state_q;
    logic [5:0] op;
    logic       op_r, op_lw, op_sw, op_beq, op_j, op_halt;
    logic       pc_wre;
    logic       unused_instr_bits;

    assign op      = bus.instr[31:26];
    assign op_r    = (op == OP_RTYPE);
    assign op_lw   = (op == OP_LW);
    assign op_sw   = (op == OP_SW);
    assign op_beq  = (op == OP_BEQ);
    assign op_j    = (op == OP_J);
    assign op_halt = (op == OP_HALT);
    assign unused_instr_bits = ^bus.instr[25:0];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:  state_q <= S_ID;
                S_ID: begin
                    if (op_halt)
                        state_q <= S_HALT;
                    else if (op_r || op_lw || op_sw || op_beq)
                        state_q <= S_EXE;
                    else
                        state_q <= S_IF;   // J and unknown opcodes retire here
                end
                S_EXE: begin
                    if (op_r)
                        state_q <= S_WB;
                    else if (op_lw || op_sw)
                        state_q <= S_MEM;
                    else
                        state_q <= S_IF;
                end
                S_MEM: begin
                    if (bus.mem_ready)
                        state_q <= op_lw ? S_WB : S_IF;
                end
                S_WB:   state_q <= S_IF;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is
    // inferred for paths that do not mention it.
    always_comb begin
        bus.IRWre    = 1'b0;
        pc_wre       = 1'b0;
        bus.RegWre   = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.halted   = 1'b0;
        case (state_q)
            S_IF:  bus.IRWre = 1'b1;
            S_ID:  pc_wre    = !(op_halt || op_r || op_lw || op_sw || op_beq);
            S_EXE: pc_wre    = !(op_r || op_lw || op_sw);
            S_MEM: begin
                bus.MemRead  = op_lw;
                bus.MemWrite = op_sw;
                pc_wre       = bus.mem_ready && !op_lw;
            end
            S_WB: begin
                bus.RegWre = 1'b1;
                pc_wre     = 1'b1;
            end
            S_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCWre = pc_wre;
    assign bus.state = state_q;

`ifdef MC_STAGE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] retire_cnt_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            if (state_q != S_HALT)
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (pc_wre)
                retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
`else
    assign bus.cycle_cnt  = 32'd0;
    assign bus.retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_stage_ctrl.sv
// Directed, table-driven bench for mc_stage_ctrl; counter checks adapt to
// whether MC_STAGE_CTRL_PERF_EN is defined.
module tb_mc_stage_ctrl;

    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    mc_stage_ctrl_if bus ();

    mc_stage_ctrl dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        mem_ready;
        logic [2:0]  st;
        logic [5:0]  outs;   // {IRWre, PCWre, RegWre, MemRead, MemWrite, halted}
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    localparam logic [31:0] I_R    = 32'h0000_0020;
    localparam logic [31:0] I_LW   = 32'h8C01_0004;
    localparam logic [31:0] I_SW   = 32'hAC01_0004;
    localparam logic [31:0] I_BEQ  = 32'h1000_0000;
    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_NOP  = 32'hE000_0000;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs_now();
        return {bus.IRWre, bus.PCWre, bus.RegWre, bus.MemRead, bus.MemWrite, bus.halted};
    endfunction

    task automatic check_counters(input string name, input logic [31:0] cyc, input logic [31:0] ret);
`ifdef MC_STAGE_CTRL_PERF_EN
        check({name, "_cycle"},  bus.cycle_cnt,  cyc);
        check({name, "_retire"}, bus.retire_cnt, ret);
`else
        check({name, "_cycle"},  bus.cycle_cnt,  32'd0 & cyc);
        check({name, "_retire"}, bus.retire_cnt, 32'd0 & ret);
`endif
    endtask

    initial begin
        int exp_retire;
        int halt_cycle;
        checks = 0;
        errors = 0;

        // R-type, LW with two wait cycles, SW with zero wait, BEQ, J, NOP
        vecs[0]  = '{I_R,   1'b0, 3'd0, 6'b100000};
        vecs[1]  = '{I_R,   1'b0, 3'd1, 6'b000000};
        vecs[2]  = '{I_R,   1'b1, 3'd2, 6'b000000};
        vecs[3]  = '{I_R,   1'b0, 3'd4, 6'b011000};
        vecs[4]  = '{I_LW,  1'b1, 3'd0, 6'b100000};
        vecs[5]  = '{I_LW,  1'b1, 3'd1, 6'b000000};
        vecs[6]  = '{I_LW,  1'b1, 3'd2, 6'b000000};
        vecs[7]  = '{I_LW,  1'b0, 3'd3, 6'b000100};
        vecs[8]  = '{I_LW,  1'b0, 3'd3, 6'b000100};
        vecs[9]  = '{I_LW,  1'b1, 3'd3, 6'b000100};
        vecs[10] = '{I_LW,  1'b0, 3'd4, 6'b011000};
        vecs[11] = '{I_SW,  1'b1, 3'd0, 6'b100000};
        vecs[12] = '{I_SW,  1'b1, 3'd1, 6'b000000};
        vecs[13] = '{I_SW,  1'b1, 3'd2, 6'b000000};
        vecs[14] = '{I_SW,  1'b1, 3'd3, 6'b010010};
        vecs[15] = '{I_BEQ, 1'b0, 3'd0, 6'b100000};
        vecs[16] = '{I_BEQ, 1'b1, 3'd1, 6'b000000};
        vecs[17] = '{I_BEQ, 1'b0, 3'd2, 6'b010000};
        vecs[18] = '{I_J,   1'b0, 3'd0, 6'b100000};
        vecs[19] = '{I_J,   1'b1, 3'd1, 6'b010000};
        vecs[20] = '{I_NOP, 1'b0, 3'd0, 6'b100000};
        vecs[21] = '{I_NOP, 1'b0, 3'd1, 6'b010000};

        // Reset state, then reset asserted while an LW sits in MEM
        Reset         = 1'b0;
        bus.instr     = I_LW;
        bus.mem_ready = 1'b0;
        @(negedge CLK);
        check("reset_state", {29'd0, bus.state}, 32'd0);
        check("reset_outs",  {26'd0, outs_now()}, 32'b100000);
        check_counters("reset", 32'd0, 32'd0);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("pre_reset_mem_state", {29'd0, bus.state}, 32'd3);
        check("pre_reset_mem_outs",  {26'd0, outs_now()}, 32'b000100);
        #2 Reset = 1'b0;
        #1;
        check("async_reset_state", {29'd0, bus.state}, 32'd0);
        check("async_reset_outs",  {26'd0, outs_now()}, 32'b100000);
        check_counters("async_reset", 32'd0, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        exp_retire = 0;
        for (int i = 0; i < NVEC; i++) begin
            bus.instr     = vecs[i].instr;
            bus.mem_ready = vecs[i].mem_ready;
            #1;
            check($sformatf("row%0d_state", i), {29'd0, bus.state}, {29'd0, vecs[i].st});
            check($sformatf("row%0d_outs", i),  {26'd0, outs_now()}, {26'd0, vecs[i].outs});
            check_counters($sformatf("row%0d", i), i, exp_retire);
            if (vecs[i].outs[4]) exp_retire++;
            @(negedge CLK);
        end

        // HALT: IF, ID, then parked in HALT until reset
        halt_cycle    = NVEC + 2;
        bus.instr     = I_HALT;
        bus.mem_ready = 1'b0;
        #1 check("halt_if_state", {29'd0, bus.state}, 32'd0);
        @(negedge CLK);
        #1 check("halt_id_outs", {26'd0, outs_now()}, 32'b000000);
        @(negedge CLK);
        for (int k = 0; k < 10; k++) begin
            bus.mem_ready = k[0];
            #1;
            check($sformatf("halt%0d_state", k), {29'd0, bus.state}, 32'd5);
            check($sformatf("halt%0d_outs", k),  {26'd0, outs_now()}, 32'b000001);
            check_counters($sformatf("halt%0d", k), halt_cycle, exp_retire);
            @(negedge CLK);
        end
        #2 Reset = 1'b0;
        #1 check("halt_reset_state", {29'd0, bus.state}, 32'd0);
        check("halt_reset_outs", {26'd0, outs_now()}, 32'b100000);
        @(negedge CLK);
        Reset     = 1'b1;
        bus.instr = I_J;

`ifdef MC_STAGE_CTRL_PERF_EN
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.cycle_cnt_q;
        repeat (3) @(negedge CLK);
        #1 check("cycle_wrap", bus.cycle_cnt, 32'd1);
`else
        repeat (3) @(negedge CLK);
        #1 check("cycle_absent", bus.cycle_cnt, 32'd0);
        check("retire_absent", bus.retire_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
